// File: rtl/priority_arbiter_pkg.sv
// Shared types and constants for the request arbiter.
// Holds the grant FSM state encoding and the priority-mode selectors.
// No logic lives here; it is imported by the arbiter and its encoder.
package priority_arbiter_pkg;

   // Grant FSM: IDLE offers nothing, HOLD offers a registered grant.
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Values accepted by the RR_MODE parameter.
   localparam int PRIO_FIXED = 0;
   localparam int PRIO_RR    = 1;

   // Supported request-vector width range.
   localparam int MIN_N = 2;
   localparam int MAX_N = 32;

endpackage

// File: rtl/priority_encoder_n.sv
// Purpose: combinational priority encoder, highest set index wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output tracks the input vector continuously.
module priority_encoder_n
   import priority_arbiter_pkg::*;
#(
   parameter int N  = 8,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  in_i,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   // Scan upward so the highest set bit is the last one written.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (in_i[i]) begin
            idx_o = IW'(i);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/priority_arbiter.sv
// Purpose: N-way request arbiter, fixed or round-robin priority, valid/ready grant.
// Latency: grant_valid rises 1 cycle after a nonzero req is sampled in IDLE.
// Backpressure: grant is held stable until grant_ready; at most one grant per 2 cycles.
module priority_arbiter
   import priority_arbiter_pkg::*;
#(
   parameter int N       = 8,
   parameter int RR_MODE = 0,
   localparam int IW     = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   output logic          grant_valid,
   input  logic          grant_ready,
   output logic [IW-1:0] grant_idx,
   output logic [N-1:0]  grant_onehot
);

   state_t        state_q, state_d;
   logic [IW-1:0] grant_idx_q, grant_idx_d;

   // Winner of the current arbitration round, supplied by the mode-specific logic.
   logic [IW-1:0] win_idx;
   logic          win_any;

   // ------------------------------------------------------------------
   // Winner selection
   // ------------------------------------------------------------------
   if (RR_MODE == PRIO_RR) begin : g_rr
      logic [IW-1:0] ptr_q, ptr_d;
      logic [N-1:0]  req_masked;
      logic [IW-1:0] masked_idx, full_idx;
      logic          masked_any, full_any;
      logic          accept;

      // The grant is consumed only while it is actually on offer.
      assign accept = (state_q == HOLD) && grant_ready;

      // Keep only requests strictly below ptr: they form the top of the
      // descending order starting at ptr-1. ptr=0 leaves this empty, so the
      // unmasked encoder then hands top priority to N-1.
      always_comb begin
         req_masked = '0;
         for (int i = 0; i < N; i++) begin
            req_masked[i] = req[i] && (IW'(i) < ptr_q);
         end
      end

      priority_encoder_n #(.N(N)) u_enc_masked (
         .in_i  (req_masked),
         .idx_o (masked_idx),
         .any_o (masked_any)
      );

      priority_encoder_n #(.N(N)) u_enc_full (
         .in_i  (req),
         .idx_o (full_idx),
         .any_o (full_any)
      );

      // Requests below ptr take precedence; otherwise wrap to the full vector.
      always_comb begin
         win_idx = masked_any ? masked_idx : full_idx;
         win_any = full_any;
      end

      // The pointer moves to the index just consumed, so that index drops to lowest priority.
      always_comb begin
         ptr_d = ptr_q;
         if (accept) begin
            ptr_d = grant_idx_q;
         end
      end

      // Round-robin pointer register.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ptr_q <= '0;
         end else begin
            ptr_q <= ptr_d;
         end
      end
   end else begin : g_fixed
      priority_encoder_n #(.N(N)) u_enc (
         .in_i  (req),
         .idx_o (win_idx),
         .any_o (win_any)
      );
   end

   // ------------------------------------------------------------------
   // Grant FSM
   // ------------------------------------------------------------------

   // Next-state: arbitrate only from IDLE; no re-arbitration on the acceptance edge.
   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      case (state_q)
         IDLE: begin
            if (win_any) begin
               state_d     = HOLD;
               grant_idx_d = win_idx;
            end
         end
         HOLD: begin
            if (grant_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and grant index registers; the index persists through IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
      end
   end

   // Outputs come straight from flops, so reset clears them without a clock.
   always_comb begin
      grant_valid  = (state_q == HOLD);
      grant_idx    = grant_idx_q;
      grant_onehot = '0;
      if (state_q == HOLD) begin
         grant_onehot = N'(1) << grant_idx_q;
      end
   end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 The block SHALL expose parameter N, default 8, meaning the number of request lines (legal range 2..32).
REQ-002 The block SHALL expose parameter RR_MODE, default 0, meaning 0 = fixed priority and 1 = round-robin priority.
REQ-003 The block SHALL derive local parameter IW = $clog2(N) as the grant index width.
REQ-004 The block SHALL provide port: clk  input  1  single clock, all state on its rising edge.
REQ-005 The block SHALL provide port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL provide port: req  input  N  request vector; several bits may be high at once.
REQ-007 The block SHALL provide port: grant_valid  output  1  a registered grant is being offered.
REQ-008 The block SHALL provide port: grant_ready  input  1  the consumer accepts the offered grant.
REQ-009 The block SHALL provide port: grant_idx  output  IW  binary index of the granted request.
REQ-010 The block SHALL provide port: grant_onehot  output  N  one-hot form of grant_idx; all zero when grant_valid is 0.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (no grant offered) and HOLD (grant offered).
REQ-012 In IDLE with req == 0, the FSM SHALL remain in IDLE and all outputs SHALL stay 0.
REQ-013 In IDLE with req != 0 at a rising edge, the block SHALL register the winner, set grant_valid and move to HOLD; latency is 1 cycle from the sampled req to grant_valid.
REQ-014 With RR_MODE=0, the winner SHALL be the highest set index (req[N-1] highest, req[0] lowest).
REQ-015 With RR_MODE=1, the priority order SHALL be descending from index (ptr-1) mod N, wrapping from 0 to N-1; ptr is an IW-bit register.
REQ-016 In HOLD, grant_idx, grant_onehot and grant_valid SHALL stay constant until grant_ready is sampled high, even if req changes or drops to 0.
REQ-017 In HOLD with grant_ready high at a rising edge, the FSM SHALL return to IDLE, clear grant_valid and grant_onehot, and (RR_MODE=1 only) load ptr with grant_idx.
REQ-018 The block SHALL not re-arbitrate in the acceptance cycle; maximum throughput is one grant per 2 cycles.
REQ-019 grant_ready while in IDLE SHALL have no effect.
REQ-020 In round-robin mode, the wrap case ptr = 0 SHALL give index N-1 the highest priority.
REQ-021 grant_idx SHALL hold its last value in IDLE; only grant_onehot is forced to 0.

Reset
REQ-022 Asserting rst_n low SHALL immediately force the FSM to IDLE, grant_valid to 0, grant_idx to 0, grant_onehot to 0 and ptr to 0, including during HOLD.
REQ-023 After rst_n deasserts, the first arbitration SHALL occur at the first rising edge on which req != 0.

Structure
REQ-024 A package priority_arbiter_pkg SHALL hold the FSM state typedef (IDLE, HOLD) and the RR_MODE encodings (PRIO_FIXED = 0, PRIO_RR = 1).
REQ-025 Arbitration SHALL use one combinational sub-module, priority_encoder_n (parameter N, input vector, output index plus any-bit flag, highest index wins).
REQ-026 Round-robin SHALL be built from two priority_encoder_n instances: one on req masked to indices below ptr, one on unmasked req; the masked result wins when its any-bit flag is set.

Verification
REQ-027 N=4, RR_MODE=0, req=0110, grant_ready=1 -> grant_valid high one cycle after sampling, grant_idx=2, grant_onehot=0100.
REQ-028 N=4, RR_MODE=0, req=1111, grant_ready held 0 for 5 cycles while req changes to 0001 -> grant_idx stays 3 throughout; after grant_ready=1, grant_idx=0 on the next grant.
REQ-029 N=4, RR_MODE=1, req=1111 constant, grant_ready=1 -> grant sequence 3, 2, 1, 0, 3, with one idle cycle between grants.
REQ-030 N=4, RR_MODE=1, after a grant of 0 (ptr=0), req=1001 -> grant_idx=3 (wrap case).
REQ-031 rst_n pulsed low mid-HOLD with grant_idx=2 -> outputs become 0 asynchronously, before the next clock edge; with RR_MODE=1 the next grant restarts from index N-1.
REQ-032 N=8, req=0 for 10 cycles -> grant_valid stays 0 and grant_onehot stays 00000000.
